// File: rtl/axil_rr_arbiter.sv
// Two-requester round-robin front end for a single AXI-Lite master port.
// One transaction in flight; response is returned as a one-cycle pulse to the winner.
module axil_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [1:0]              req_valid_i,
  input  logic [1:0]              req_write_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  output logic [1:0]              req_ready_o,
  output logic [1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,

  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,

  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,

  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,

  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,

  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_q, grant_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic                   bready_q, bready_d;
  logic                   rready_q, rready_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             resp_q, resp_d;

  logic                   win_c;
  logic [ADDR_WIDTH-1:0]  win_addr_c;
  logic [DATA_WIDTH-1:0]  win_wdata_c;
  logic [1:0]             req_ready_c;
  logic                   aw_done_c;
  logic                   w_done_c;
  logic                   ar_done_c;

  // Round-robin pick: a tie goes to whoever did not win last time.
  always_comb begin
    win_c = 1'b0;
    if (req_valid_i == 2'b11) begin
      win_c = ~last_grant_q;
    end else if (req_valid_i[1]) begin
      win_c = 1'b1;
    end
    win_addr_c  = win_c ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                        : req_addr_i[ADDR_WIDTH-1:0];
    win_wdata_c = win_c ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                        : req_wdata_i[DATA_WIDTH-1:0];
  end

  // A channel counts as done once its valid has dropped or handshakes this cycle.
  assign aw_done_c = !awvalid_q || m_awready;
  assign w_done_c  = !wvalid_q  || m_wready;
  assign ar_done_c = !arvalid_q || m_arready;

  // Next-state and datapath capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    req_ready_c  = 2'b00;

    case (state_q)
      IDLE: begin
        if (req_valid_i != 2'b00) begin
          req_ready_c  = win_c ? 2'b10 : 2'b01;
          grant_d      = win_c;
          last_grant_d = win_c;
          if (req_write_i[win_c]) begin
            state_d   = WRITE;
            awaddr_d  = win_addr_c;
            wdata_d   = win_wdata_c;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            araddr_d  = win_addr_c;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q  && !m_wready;
        if (m_bvalid && bready_q && aw_done_c && w_done_c) begin
          resp_d  = m_bresp;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      READ: begin
        arvalid_d = arvalid_q && !m_arready;
        if (m_rvalid && rready_q && ar_done_c) begin
          resp_d  = m_rresp;
          rdata_d = m_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready strobes and the response pulse follow the state being entered.
  always_comb begin
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    rsp_valid_d = 2'b00;
    case (state_d)
      WRITE:   bready_d = 1'b1;
      READ:    rready_d = 1'b1;
      RESP:    rsp_valid_d = grant_d ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      rsp_valid_q  <= rsp_valid_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  // Acceptance is combinational, so it must also be masked while reset is held.
  assign req_ready_o = rst_i ? 2'b00 : req_ready_c;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;

  assign m_awaddr  = awaddr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = {STRB_WIDTH{1'b1}};
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter with a delay-programmable AXI-Lite slave.
module tb_axil_rr_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready_o, rsp_valid_o, rsp_resp_o;
  logic [DW-1:0]   rsp_rdata_o;

  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [2:0]      m_awprot, m_arprot;
  logic            m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic [1:0]      m_bresp, m_rresp;
  logic            m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int checks = 0;
  int errors = 0;

  // Slave configuration
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]    bresp_v = 2'b00, rresp_v = 2'b00;
  logic [DW-1:0] rdata_v = '0;
  logic          stray_rvalid = 1'b0;

  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_hs, w_hs, ar_hs;

  always #5 clk = ~clk;

  axil_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Slave: ready after N waiting cycles, response N cycles after address/data complete.
  assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
  assign m_wready  = m_wvalid  && (w_cnt  >= w_dly);
  assign m_arready = m_arvalid && (ar_cnt >= ar_dly);
  assign m_bvalid  = aw_hs && w_hs && (b_cnt >= b_dly);
  assign m_rvalid  = (ar_hs && (r_cnt >= r_dly)) || stray_rvalid;
  assign m_bresp   = bresp_v;
  assign m_rresp   = rresp_v;
  assign m_rdata   = rdata_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_hs <= 1'b0; w_hs <= 1'b0; ar_hs <= 1'b0;
    end else begin
      if (m_awvalid && m_awready) begin aw_hs <= 1'b1; aw_cnt <= 0; end
      else if (m_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_wvalid && m_wready) begin w_hs <= 1'b1; w_cnt <= 0; end
      else if (m_wvalid) w_cnt <= w_cnt + 1;
      if (m_arvalid && m_arready) begin ar_hs <= 1'b1; ar_cnt <= 0; end
      else if (m_arvalid) ar_cnt <= ar_cnt + 1;
      if (m_bvalid && m_bready) begin aw_hs <= 1'b0; w_hs <= 1'b0; b_cnt <= 0; end
      else if (aw_hs && w_hs) b_cnt <= b_cnt + 1;
      if (m_rvalid && m_rready) begin ar_hs <= 1'b0; r_cnt <= 0; end
      else if (ar_hs) r_cnt <= r_cnt + 1;
    end
  end

  task automatic drive_pt();
    @(posedge clk); #1;
  endtask

  task automatic sample_pt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    sample_pt(); sample_pt();
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", req_ready_o); end
    checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin errors++;
      $display("FAIL rst_handshakes got=%b exp=00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid_o); end
    checks++; if ({rsp_rdata_o, rsp_resp_o} !== 34'h0) begin errors++; $display("FAIL rst_rsp_data got=%h/%b exp=0/00", rsp_rdata_o, rsp_resp_o); end
    checks++; if ({m_awaddr, m_araddr, m_wdata} !== 40'h0) begin errors++; $display("FAIL rst_addr_data got=%h %h %h exp=0", m_awaddr, m_araddr, m_wdata); end
    checks++; if ({m_wstrb, m_awprot, m_arprot} !== 10'b1111_000_000) begin errors++;
      $display("FAIL rst_strb_prot got=%b %b %b exp=1111 000 000", m_wstrb, m_awprot, m_arprot); end
    drive_pt(); rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_write_zero_wait();
    drive_pt();
    bresp_v = 2'b00; req_valid = 2'b01; req_write = 2'b01;
    req_addr = {4'h9, 4'h4}; req_wdata = {32'h1111_2222, 32'hDEAD_BEEF};
    sample_pt();  // accept cycle
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL wr_accept got=%b exp=01", req_ready_o); end
    checks++; if ({m_awvalid, m_wvalid} !== 2'b00) begin errors++; $display("FAIL wr_early_valid got=%b exp=00", {m_awvalid, m_wvalid}); end
    drive_pt(); req_valid = 2'b00; sample_pt();
    checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b111) begin errors++; $display("FAIL wr_aw_w_valid got=%b exp=111", {m_awvalid, m_wvalid, m_bready}); end
    checks++; if ({m_awaddr, m_wdata} !== {4'h4, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_payload got=%h %h exp=4 deadbeef", m_awaddr, m_wdata); end
    drive_pt(); req_valid = 2'b10; req_write = 2'b00; sample_pt();
    checks++; if ({m_awvalid, m_wvalid, m_bready, m_bvalid} !== 4'b0011) begin errors++;
      $display("FAIL wr_bphase got=%b exp=0011", {m_awvalid, m_wvalid, m_bready, m_bvalid}); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL wr_busy_ready got=%b exp=00", req_ready_o); end
    drive_pt(); req_valid = 2'b00; sample_pt();
    checks++; if ({rsp_valid_o, rsp_resp_o, rsp_rdata_o} !== {2'b01, 2'b00, 32'h0}) begin errors++;
      $display("FAIL wr_rsp got=%b %b %h exp=01 00 0", rsp_valid_o, rsp_resp_o, rsp_rdata_o); end
    checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL wr_bready_resp got=%b exp=0", m_bready); end
    drive_pt(); req_valid = 2'b01; req_write = 2'b00; sample_pt();
    checks++; if ({rsp_valid_o, req_ready_o} !== 4'b0001) begin errors++;
      $display("FAIL wr_period4 got=%b %b exp=00 01", rsp_valid_o, req_ready_o); end
    drive_pt(); req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    rst = 1'b1;
    drive_pt();
    rst = 1'b0; req_valid = 2'b11; req_write = 2'b00; req_addr = {4'h2, 4'h1};
    rdata_v = 32'h0000_1111; rresp_v = 2'b00;
    for (int i = 0; i < 16; i++) begin
      sample_pt();
      exp_g = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready_o !== ((i % 4 == 0) ? exp_g : 2'b00)) begin errors++;
        $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, req_ready_o, (i % 4 == 0) ? exp_g : 2'b00); end
      checks++; if (rsp_valid_o !== ((i % 4 == 3) ? exp_g : 2'b00)) begin errors++;
        $display("FAIL b2b_rsp cyc=%0d got=%b exp=%b", i, rsp_valid_o, (i % 4 == 3) ? exp_g : 2'b00); end
      if (i == 1) begin
        checks++; if ({m_arvalid, m_araddr} !== {1'b1, 4'h1}) begin errors++; $display("FAIL b2b_araddr got=%b %h exp=1 1", m_arvalid, m_araddr); end
      end
      if (i == 3) begin
        checks++; if (rsp_rdata_o !== 32'h0000_1111) begin errors++; $display("FAIL b2b_rdata got=%h exp=00001111", rsp_rdata_o); end
      end
      drive_pt();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_read_wait();
    req_valid = 2'b10; req_write = 2'b00; req_addr = {4'h8, 4'h3};
    ar_dly = 3; rdata_v = 32'h1234_5678; rresp_v = 2'b10;
    sample_pt();
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rd_accept got=%b exp=10", req_ready_o); end
    drive_pt(); req_valid = 2'b00; req_addr = 8'h00;
    for (int j = 1; j <= 4; j++) begin
      sample_pt();
      checks++; if ({m_arvalid, m_araddr, m_rready, m_arready} !== {1'b1, 4'h8, 1'b1, (j == 4)}) begin errors++;
        $display("FAIL rd_ar_hold cyc=%0d got=%b %h %b %b exp=1 8 1 %b", j, m_arvalid, m_araddr, m_rready, m_arready, (j == 4)); end
      drive_pt();
    end
    sample_pt();
    checks++; if ({m_arvalid, m_rvalid, rsp_valid_o} !== 4'b0100) begin errors++;
      $display("FAIL rd_rphase got=%b %b %b exp=0 1 00", m_arvalid, m_rvalid, rsp_valid_o); end
    drive_pt(); sample_pt();
    checks++; if ({rsp_valid_o, rsp_rdata_o, rsp_resp_o} !== {2'b10, 32'h1234_5678, 2'b10}) begin errors++;
      $display("FAIL rd_rsp got=%b %h %b exp=10 12345678 10", rsp_valid_o, rsp_rdata_o, rsp_resp_o); end
    drive_pt(); sample_pt();
    checks++; if ({rsp_valid_o, rsp_rdata_o, rsp_resp_o} !== {2'b00, 32'h1234_5678, 2'b10}) begin errors++;
      $display("FAIL rd_hold got=%b %h %b exp=00 12345678 10", rsp_valid_o, rsp_rdata_o, rsp_resp_o); end
    drive_pt();
    ar_dly = 0;
  endtask

  task automatic test_write_split();
    logic [4:0] exp_v [1:5];
    exp_v[1] = 5'b11100; exp_v[2] = 5'b10000; exp_v[3] = 5'b10010; exp_v[4] = 5'b00000; exp_v[5] = 5'b00001;
    req_valid = 2'b01; req_write = 2'b01; req_addr = {4'h0, 4'hC}; req_wdata = {32'h0, 32'hA5A5_0F0F};
    aw_dly = 2; w_dly = 0; b_dly = 1; bresp_v = 2'b11;
    sample_pt();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL ws_accept got=%b exp=01", req_ready_o); end
    drive_pt(); req_valid = 2'b00; req_wdata = '0; req_addr = '0;
    // {awvalid, wvalid, wready, awready, bvalid}
    for (int j = 1; j <= 5; j++) begin
      sample_pt();
      checks++; if ({m_awvalid, m_wvalid, m_wready, m_awready, m_bvalid} !== exp_v[j]) begin errors++;
        $display("FAIL ws_chan cyc=%0d got=%b exp=%b", j, {m_awvalid, m_wvalid, m_wready, m_awready, m_bvalid}, exp_v[j]); end
      checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL ws_early_rsp cyc=%0d got=%b exp=00", j, rsp_valid_o); end
      if (j <= 3) begin
        checks++; if ({m_awaddr, m_wdata} !== {4'hC, 32'hA5A5_0F0F}) begin errors++;
          $display("FAIL ws_stable cyc=%0d got=%h %h exp=c a5a50f0f", j, m_awaddr, m_wdata); end
      end
      drive_pt();
    end
    sample_pt();
    checks++; if ({rsp_valid_o, rsp_resp_o, rsp_rdata_o} !== {2'b01, 2'b11, 32'h0}) begin errors++;
      $display("FAIL ws_rsp got=%b %b %h exp=01 11 0", rsp_valid_o, rsp_resp_o, rsp_rdata_o); end
    drive_pt(); sample_pt();
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL ws_single_pulse got=%b exp=00", rsp_valid_o); end
    drive_pt();
    aw_dly = 0; b_dly = 0;
  endtask

  task automatic test_reset_mid_read();
    req_valid = 2'b01; req_write = 2'b00; req_addr = {4'h0, 4'h6}; r_dly = 5;
    sample_pt();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL mr_accept got=%b exp=01", req_ready_o); end
    drive_pt(); req_valid = 2'b00;
    drive_pt(); sample_pt();
    checks++; if ({m_rready, m_rvalid, m_arvalid} !== 3'b100) begin errors++;
      $display("FAIL mr_wait got=%b exp=100", {m_rready, m_rvalid, m_arvalid}); end
    drive_pt();
    rst = 1'b1; req_valid = 2'b11;
    #1;
    checks++; if ({m_rready, m_arvalid, m_bready, m_awvalid, m_wvalid, req_ready_o, rsp_valid_o} !== 9'b0) begin errors++;
      $display("FAIL mr_rst_ctrl got=%b exp=0", {m_rready, m_arvalid, m_bready, m_awvalid, m_wvalid, req_ready_o, rsp_valid_o}); end
    checks++; if ({rsp_resp_o, m_araddr} !== 6'b0) begin errors++; $display("FAIL mr_rst_data got=%b %h exp=00 0", rsp_resp_o, m_araddr); end
    drive_pt();
    rst = 1'b0; req_valid = 2'b00; stray_rvalid = 1'b1; rdata_v = 32'hBADB_AD00;
    for (int j = 0; j < 3; j++) begin
      sample_pt();
      checks++; if ({rsp_valid_o, rsp_rdata_o, m_rready} !== 35'h0) begin errors++;
        $display("FAIL mr_stray cyc=%0d got=%b %h %b exp=00 0 0", j, rsp_valid_o, rsp_rdata_o, m_rready); end
      drive_pt();
    end
    stray_rvalid = 1'b0; r_dly = 0; req_valid = 2'b11;
    sample_pt();
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL mr_tie_after_rst got=%b exp=01", req_ready_o); end
    drive_pt(); req_valid = 2'b00;
    repeat (4) drive_pt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_zero_wait();
    test_back_to_back();
    test_read_wait();
    test_write_split();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_rr_arbiter.md
AXIL_RR_ARBITER -- requirements
Module: axil_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; wstrb width DATA_WIDTH/8.
REQ-003 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have port req_valid_i  in  2  per-requester command valid (bit n = requester n).
REQ-006 SHALL have port req_write_i  in  2  per-requester 1=write, 0=read.
REQ-007 SHALL have port req_addr_i  in  2*ADDR_WIDTH  requester n address in slice n.
REQ-008 SHALL have port req_wdata_i  in  2*DATA_WIDTH  requester n write data in slice n.
REQ-009 SHALL have port req_ready_o  out  2  command accepted this cycle (one-hot or zero).
REQ-010 SHALL have port rsp_valid_o  out  2  response pulse to requester n (one-hot or zero).
REQ-011 SHALL have port rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes).
REQ-012 SHALL have port rsp_resp_o  out  2  captured bresp or rresp.
REQ-013 SHALL have AXI-Lite master ports m_awaddr/m_awprot/m_awvalid (out), m_awready (in).
REQ-014 SHALL have m_wdata/m_wstrb/m_wvalid (out), m_wready (in).
REQ-015 SHALL have m_bresp/m_bvalid (in), m_bready (out).
REQ-016 SHALL have m_araddr/m_arprot/m_arvalid (out), m_arready (in).
REQ-017 SHALL have m_rdata/m_rresp/m_rvalid (in), m_rready (out).

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, RESP; one transaction outstanding max.
REQ-019 IDLE: if any req_valid_i set, SHALL grant one requester, assert its req_ready_o combinationally that cycle, register its write/addr/wdata and index, go WRITE or READ.
REQ-020 Arbitration SHALL be round-robin: single requester wins; both valid -> requester other than last_grant wins; last_grant updates on every grant.
REQ-021 req_ready_o SHALL be 0 in all states except IDLE.
REQ-022 WRITE: m_awvalid and m_wvalid SHALL assert from the cycle after acceptance; each deasserts independently after its own valid&ready handshake; m_bready high throughout WRITE.
REQ-023 WRITE SHALL exit to RESP only on m_bvalid&&m_bready after both AW and W handshakes have completed (same-cycle completions allowed); bresp captured.
REQ-024 READ: m_arvalid asserts from the cycle after acceptance until m_arready; m_rready high throughout READ; m_rvalid after AR handshake -> capture rdata/rresp, go RESP.
REQ-025 Addresses/data on m_aw*/m_w*/m_ar* SHALL stay stable while the associated valid is high.
REQ-026 RESP: rsp_valid_o[granted] SHALL be 1 for exactly one cycle with captured rsp_rdata_o/rsp_resp_o, then IDLE; no backpressure on responses.
REQ-027 m_wstrb SHALL be all ones; m_awprot and m_arprot SHALL be 0.
REQ-028 rsp_rdata_o and rsp_resp_o SHALL hold last captured values outside RESP.
REQ-029 Minimum command-to-command period SHALL be 4 cycles (accept, addr handshake, response, RESP) with zero-wait slave.
REQ-030 Slave responses (bvalid/rvalid) outside the matching state SHALL be ignored.

Reset
REQ-031 rst_i high SHALL immediately force state IDLE, all m_*valid, m_bready, m_rready, req_ready_o, rsp_valid_o to 0.
REQ-032 Reset SHALL clear m_awaddr, m_araddr, m_wdata, rsp_rdata_o, rsp_resp_o to 0 and last_grant to 1 (requester 0 wins first tie).
REQ-033 Reset mid-transaction SHALL abandon it with no rsp_valid_o pulse.

Verification
REQ-034 Req0 write addr 0x4 data 0xDEADBEEF, slave zero-wait bresp 0 -> awvalid/wvalid cycle after accept, rsp_valid_o=01 with resp 0, four cycles total.
REQ-035 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; each req_ready_o one-cycle pulse.
REQ-036 Req1 read addr 0x8, slave delays arready 3 cycles, rdata 0x12345678 -> arvalid held stable 3 cycles, rsp_valid_o=10, rsp_rdata_o 0x12345678.
REQ-037 Write with wready 2 cycles before awready, bvalid later -> wvalid drops first, awvalid later, single response pulse.
REQ-038 rst_i asserted during READ wait for rvalid -> all outputs 0 same cycle, late rvalid ignored, next tie granted to requester 0.
